fifo_param: RTL

FIFO_PARAM -- requirements
Module: fifo_param

---
 rtl/fifo_param.sv | 93 +++++++++
 1 files changed

// File: rtl/fifo_param.sv
// fifo_param: synchronous FIFO with registered read data, occupancy count and status flags.
// Ports: Clk/Rst (sync, active-high), EN global enable, WR/RD requests, dataIn write word,
// dataOut/dataValid registered read word and its valid strobe, Count occupancy 0..DEPTH,
// EMPTY/FULL/ALMOST_EMPTY/ALMOST_FULL flags decoded from Count.
// Define FIFO_PARAM_ERR_FLAGS_EN to add sticky OVF/UDF error outputs.
module fifo_param #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic                       EN,
  input  logic                       WR,
  input  logic                       RD,
  input  logic [DATA_W-1:0]          dataIn,
  output logic [DATA_W-1:0]          dataOut,
  output logic                       dataValid,
  output logic [$clog2(DEPTH):0]     Count,
  output logic                       EMPTY,
  output logic                       FULL,
  output logic                       ALMOST_EMPTY,
`ifdef FIFO_PARAM_ERR_FLAGS_EN
  output logic                       ALMOST_FULL,
  output logic                       OVF,
  output logic                       UDF
`else
  output logic                       ALMOST_FULL
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dvalid_q;
  logic              wr_acc, rd_acc;
  assign EMPTY        = count_q == '0;
  assign FULL         = count_q == CW'(DEPTH);
  assign ALMOST_FULL  = count_q >= CW'(AF_LEVEL);
  assign ALMOST_EMPTY = count_q <= CW'(AE_LEVEL);
  assign Count        = count_q;
  assign dataOut      = dout_q;
  assign dataValid    = dvalid_q;
  // A read frees a slot in the same edge, so a full FIFO can still accept a write alongside it.
  assign rd_acc = EN & RD & ~EMPTY;
  assign wr_acc = EN & WR & (~FULL | rd_acc);
  always_comb begin
    wr_ptr_d = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(wr_acc) - CW'(rd_acc);
    dout_d   = rd_acc ? mem[rd_ptr_q] : dout_q;
  end
  always_ff @(posedge Clk) begin
    if (!Rst && wr_acc) mem[wr_ptr_q] <= dataIn;
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      dvalid_q <= rd_acc;
    end
  end
`ifdef FIFO_PARAM_ERR_FLAGS_EN
  logic ovf_q, ovf_d, udf_q, udf_d;
  // A read on an empty FIFO paired with a write is the benign no-bypass case, not an underflow.
  always_comb begin
    ovf_d = ovf_q | (EN & WR & FULL & ~rd_acc);
    udf_d = udf_q | (EN & RD & EMPTY & ~WR);
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end
  assign OVF = ovf_q;
  assign UDF = udf_q;
`endif
endmodule
